instr_fetch_prefetch: RTL and testbench
=======================================

Name: instr_fetch_prefetch

Overview:
Parametrised, decoupled instruction-fetch unit. It replaces the single-cycle combinational instruction-memory lookup with a request/response memory port, a bounded number of outstanding fetches, and a prefetch FIFO feeding decode through a valid/ready handshake. Redirects (jump/branch) flush the FIFO and discard stale in-flight responses. It sits between the PC-redirect logic of execute and the decode stage.

Parameters:
PC_RESET_ADDR, 32'h0000_0000, first fetch address after reset
FIFO_DEPTH, 4, prefetch FIFO entries; power of 2, >= 2
MAX_OUTSTANDING, 2, max accepted-but-unanswered memory requests; 1..FIFO_DEPTH

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
JumpFlag  in  1  one-cycle redirect strobe
JumpAddr  in  32  redirect target; bits [1:0] ignored, treated as 0
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  word-aligned fetch address
imem_rsp_valid  in  1  response valid; in order; earliest the cycle after acceptance; no backpressure
imem_rsp_data  in  32  instruction word
if_valid  out  1  head entry valid for decode
if_ready  in  1  decode accepts head entry
if_pc  out  32  PC of head entry
if_instr  out  32  instruction of head entry

Behaviour:
- Reset (async, rst_n=0): fetch_pc=PC_RESET_ADDR, rsp_pc=PC_RESET_ADDR, FIFO empty, outstanding=0, drop_cnt=0. Outputs: imem_req_valid=0, imem_req_addr=PC_RESET_ADDR, if_valid=0, if_pc=0, if_instr=0. Reset mid-transfer abandons all in-flight state. Responses arriving after reset to pre-reset requests are the memory's responsibility to squash.
- Issue: imem_req_valid = !JumpFlag && outstanding < MAX_OUTSTANDING && (outstanding + fifo_count) < FIFO_DEPTH. imem_req_addr = fetch_pc.
- Request accept: on valid&&ready, fetch_pc += 4 (mod 2^32, wraps 0xFFFF_FFFC -> 0) and outstanding++.
- Once asserted, imem_req_valid and addr stay stable until accepted, except when dropped by JumpFlag.
- Response: on imem_rsp_valid, outstanding--.
  - If drop_cnt>0: discard the response and decrement drop_cnt.
  - Else: push {rsp_pc, imem_rsp_data} into the FIFO and set rsp_pc += 4.
  - The credit rule guarantees the FIFO never overflows.
- Output: if_valid = FIFO non-empty; if_pc/if_instr = head entry (registered, 0 when empty). Pop on if_valid&&if_ready.
- Latency: response at cycle t is visible on if_valid at t+1. Minimum request-accept to decode-visible is 2 cycles.
- Redirect (JumpFlag=1 in cycle t), all effects at edge t+1:
  - FIFO cleared; a pop in the same cycle is irrelevant because flush wins.
  - fetch_pc = rsp_pc = {JumpAddr[31:2],2'b00}.
  - drop_cnt = outstanding - (imem_rsp_valid in cycle t). A response in cycle t is itself discarded.
  - No request issued in cycle t.
  - If drop_cnt>0 at redirect, stale responses are still counted in outstanding and consume credit until they return.
- Back-to-back redirects: each recomputes drop_cnt from current outstanding; the last target wins.
- Simultaneous push and pop with FIFO full is legal; count is unchanged.
- drop_cnt width is clog2(MAX_OUTSTANDING+1); outstanding uses the same width; fifo_count is clog2(FIFO_DEPTH+1).

Test Plan:
- Reset release, memory always ready, 1-cycle rsp, if_ready=1 -> req addrs 0x0,0x4,0x8...; if_pc sequence 0x0,0x4,0x8 with matching if_instr; steady throughput 1 instr/cycle when MAX_OUTSTANDING>=2.
- if_ready=0 for 10 cycles, FIFO_DEPTH=4 -> exactly 4 entries buffered, imem_req_valid drops to 0 with outstanding=0; release -> 0x0..0xC delivered in order, no loss or duplicate.
- 2 requests outstanding (0x10,0x14), JumpFlag with JumpAddr=0x103 -> both responses discarded, next req addr 0x100, first if_pc=0x100.
- JumpFlag in the same cycle as a response and an if_ready pop -> FIFO empty next cycle, that response discarded, drop_cnt = outstanding-1.
- fetch_pc=0xFFFF_FFFC -> next req addr 0x0000_0000; if_pc wraps the same way.
- Assert rst_n=0 asynchronously mid-stream (between edges) -> if_valid and imem_req_valid go to 0 immediately; after release, fetch restarts at PC_RESET_ADDR.

Source files
------------

// File: rtl/instr_fetch_prefetch.sv
// Decoupled instruction fetch: request/response memory port with bounded
// outstanding fetches and a prefetch FIFO feeding decode.
module instr_fetch_prefetch #(
  parameter logic [31:0] PC_RESET_ADDR   = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        JumpFlag,
  input  logic [31:0] JumpAddr,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = CW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] drop_cnt;
  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [31:0]   mem_pc    [FIFO_DEPTH];
  logic [31:0]   mem_instr [FIFO_DEPTH];

  logic        req_fire;
  logic        push;
  logic        pop;
  logic [31:0] target;

  assign target = {JumpAddr[31:2], 2'b00};

  // Outstanding plus buffered entries never exceeds FIFO_DEPTH,
  // so every response that is kept has a free slot.
  assign imem_req_valid = rst_n && !JumpFlag
    && (outstanding < OW'(MAX_OUTSTANDING))
    && ((SW'(outstanding) + SW'(count)) < SW'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign push     = imem_rsp_valid && (drop_cnt == '0) && !JumpFlag;
  assign pop      = if_valid && if_ready && !JumpFlag;

  assign if_valid = (count != '0);
  assign if_pc    = if_valid ? mem_pc[rd_ptr]    : 32'h0;
  assign if_instr = if_valid ? mem_instr[rd_ptr] : 32'h0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]    <= rsp_pc;
      mem_instr[wr_ptr] <= imem_rsp_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= PC_RESET_ADDR;
      rsp_pc      <= PC_RESET_ADDR;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else if (JumpFlag) begin
      // A response arriving with the redirect is itself stale.
      fetch_pc    <= target;
      rsp_pc      <= target;
      outstanding <= outstanding - OW'(imem_rsp_valid);
      drop_cnt    <= outstanding - OW'(imem_rsp_valid);
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      outstanding <= outstanding + OW'(req_fire)
                   - OW'(imem_rsp_valid);
      if (imem_rsp_valid && drop_cnt != '0)
        drop_cnt <= drop_cnt - OW'(1);
      if (push) begin
        rsp_pc <= rsp_pc + 32'd4;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_instr_fetch_prefetch.sv
// Randomized bench for instr_fetch_prefetch against a queue-based
// model of the fetch stream, memory and prefetch buffer.
module tb_instr_fetch_prefetch;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        JumpFlag = 1'b0;
  logic [31:0] JumpAddr = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  always #5 clk = ~clk;

  instr_fetch_prefetch #(
    .PC_RESET_ADDR  (32'h0),
    .FIFO_DEPTH     (DEPTH),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .JumpFlag      (JumpFlag),
    .JumpAddr      (JumpAddr),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_pc         (if_pc),
    .if_instr      (if_instr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       memq[$];
  logic [31:0] fq[$];
  logic [31:0] m_fetch;
  logic [31:0] m_rsp;
  int          m_drop;
  int          cyc = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          p_ifr = 100;
  int          p_mr = 100;
  int          p_jmp = 0;
  int          pops = 0;

  task automatic model_reset;
    memq.delete();
    fq.delete();
    m_fetch = 32'h0;
    m_rsp   = 32'h0;
    m_drop  = 0;
  endtask

  task automatic step(input bit do_jump, input logic [31:0] tgt);
    logic        exp_rv;
    logic [31:0] t;
    mreq_t       r;
    @(negedge clk);
    cyc++;
    JumpFlag = do_jump || ($urandom_range(99) < p_jmp);
    if (do_jump)
      JumpAddr = tgt;
    else if ($urandom_range(1) == 1)
      JumpAddr = 32'($urandom_range(1023));
    else
      JumpAddr = 32'hFFFF_FFE0 | 32'($urandom_range(31));
    if_ready       = $urandom_range(99) < p_ifr;
    imem_req_ready = $urandom_range(99) < p_mr;
    if (memq.size() > 0 && memq[0].due <= cyc
        && (lat_max == lat_min || $urandom_range(3) != 0)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word(memq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    exp_rv = !JumpFlag && memq.size() < MAXO
             && (memq.size() + fq.size()) < DEPTH;
    chk("req_valid", imem_req_valid, exp_rv);
    if (exp_rv) chk("req_addr", imem_req_addr, m_fetch);
    chk("if_valid", if_valid, fq.size() != 0);
    if (fq.size() != 0) begin
      chk("if_pc", if_pc, fq[0]);
      chk("if_instr", if_instr, word(fq[0]));
    end else begin
      chk("if_pc_idle", if_pc, 32'h0);
      chk("if_instr_idle", if_instr, 32'h0);
    end
    if (JumpFlag) begin
      t = {JumpAddr[31:2], 2'b00};
      m_drop = memq.size() - int'(imem_rsp_valid);
      if (imem_rsp_valid) void'(memq.pop_front());
      fq.delete();
      m_fetch = t;
      m_rsp   = t;
    end else begin
      if (fq.size() != 0 && if_ready) begin
        void'(fq.pop_front());
        pops++;
      end
      if (imem_rsp_valid) begin
        void'(memq.pop_front());
        if (m_drop > 0) begin
          m_drop--;
        end else begin
          fq.push_back(m_rsp);
          m_rsp = m_rsp + 32'd4;
        end
      end
      if (exp_rv && imem_req_ready) begin
        r.addr = imem_req_addr;
        r.due  = cyc + $urandom_range(lat_max, lat_min);
        memq.push_back(r);
        m_fetch = m_fetch + 32'd4;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0);
  endtask

  task automatic do_reset;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_if_valid", if_valid, 1'b0);
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    JumpFlag       = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    if_ready       = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    do_reset();

    // Full-rate streaming from reset.
    for (int i = 1; i <= 20; i++) begin
      if (i == 6) pops = 0;
      step(1'b0, 32'h0);
    end
    chk("throughput", pops, 15);

    // Decode stalled: buffer fills and requests stop.
    p_ifr = 0;
    run(10);
    p_ifr = 100;
    run(10);

    // Redirect with two slow fetches in flight.
    lat_min = 3;
    lat_max = 3;
    step(1'b1, 32'h10);
    run(3);
    step(1'b1, 32'h103);
    run(12);

    // Address wrap.
    lat_min = 1;
    lat_max = 1;
    step(1'b1, 32'hFFFF_FFF4);
    run(10);

    // Randomized traffic in a few regimes.
    lat_min = 1;
    lat_max = 4;
    p_ifr = 60;
    p_mr  = 70;
    p_jmp = 5;
    run(1500);
    do_reset();
    p_jmp = 15;
    p_ifr = 30;
    run(1500);
    lat_max = 1;
    p_ifr = 90;
    p_mr  = 95;
    p_jmp = 3;
    run(1500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
